// File: rtl/adder_seq_pkg.sv
// adder_seq_pkg: shared types and constants for the multi-cycle wide adder
// sequencer (adder_seq_ctrl) and its 8-bit slice datapath.
package adder_seq_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_t;

    localparam int SLICE_W = 8;

    // Width of the slice counter; a single-slice build still needs one bit.
    function automatic int idx_w(input int words);
        return (words <= 1) ? 1 : $clog2(words);
    endfunction

endpackage

// File: rtl/adder_8.sv
// adder_8: 8-bit carry-lookahead slice. Produces the sum, the carry-out and
// the signed overflow (carry-out XOR carry into bit 7) of a + b + ci.
module adder_8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       ci,
    output logic [7:0] s,
    output logic       co,
    output logic       of
);
    logic [7:0] w_g;
    logic [7:0] w_p;
    logic [8:0] w_c;

    assign w_g = a & b;
    assign w_p = a ^ b;

    // Carry lookahead: each carry expands as g | p & (previous carry).
    always_comb begin
        w_c    = '0;
        w_c[0] = ci;
        for (int i = 0; i < 8; i++) begin
            w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
        end
    end

    assign s  = w_p ^ w_c[7:0];
    assign co = w_c[8];
    assign of = w_c[8] ^ w_c[7];

endmodule

// File: rtl/adder_seq_ctrl.sv
// adder_seq_ctrl: WORDS*8-bit adder that walks one 8-bit slice per clock
// through a single shared adder_8, chaining the carry through a register.
// Request/response are valid/ready. Optional macro ADDSEQ_SUB_EN adds an
// 'op' input selecting a - b (op=1) instead of a + b.
module adder_seq_ctrl
    import adder_seq_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [SLICE_W*WORDS-1:0] a,
    input  logic [SLICE_W*WORDS-1:0] b,
    input  logic                     ci,
`ifdef ADDSEQ_SUB_EN
    input  logic                     op,
`endif
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [SLICE_W*WORDS-1:0] sum,
    output logic                     co,
    output logic                     of,
    output logic                     busy
);
    localparam int W  = SLICE_W * WORDS;
    localparam int IW = idx_w(WORDS);
    localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

    seq_state_t       r_state;
    logic [IW-1:0]    r_idx;
    logic             r_carry;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [W-1:0]     r_sum;
    logic             r_co;
    logic             r_of;
`ifdef ADDSEQ_SUB_EN
    logic             r_op;
`endif

    logic [SLICE_W-1:0] w_a_sl;
    logic [SLICE_W-1:0] w_b_sl;
    logic [SLICE_W-1:0] w_s;
    logic               w_co;
    logic               w_of;
    logic               w_cin_init;

    // Slice currently being processed; for subtraction the b slice is inverted.
    assign w_a_sl = r_a[r_idx*SLICE_W +: SLICE_W];
`ifdef ADDSEQ_SUB_EN
    assign w_b_sl     = r_op ? ~r_b[r_idx*SLICE_W +: SLICE_W] : r_b[r_idx*SLICE_W +: SLICE_W];
    assign w_cin_init = op ? 1'b1 : ci;
`else
    assign w_b_sl     = r_b[r_idx*SLICE_W +: SLICE_W];
    assign w_cin_init = ci;
`endif

    adder_8 u_slice (
        .a  (w_a_sl),
        .b  (w_b_sl),
        .ci (r_carry),
        .s  (w_s),
        .co (w_co),
        .of (w_of)
    );

    // Sequencer FSM: accept in IDLE, one slice per edge in RUN, hold in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_co    <= 1'b0;
            r_of    <= 1'b0;
`ifdef ADDSEQ_SUB_EN
            r_op    <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= w_cin_init;
                        r_idx   <= '0;
                        r_sum   <= '0;
`ifdef ADDSEQ_SUB_EN
                        r_op    <= op;
`endif
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_sum[r_idx*SLICE_W +: SLICE_W] <= w_s;
                    r_carry <= w_co;
                    r_idx   <= r_idx + IW'(1);
                    if (r_idx == LAST_IDX) begin
                        r_co    <= w_co;
                        r_of    <= w_of;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready = (r_state == IDLE);
    assign rsp_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign sum       = r_sum;
    assign co        = r_co;
    assign of        = r_of;

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// tb_adder_seq_ctrl: directed-vector bench for adder_seq_ctrl with WORDS=4.
module tb_adder_seq_ctrl;
    localparam int WORDS = 4;
    localparam int W     = 8 * WORDS;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         op;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] sum;
    logic         co;
    logic         of;
    logic         busy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    adder_seq_ctrl #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .a         (a),
        .b         (b),
        .ci        (ci),
`ifdef ADDSEQ_SUB_EN
        .op        (op),
`endif
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .sum       (sum),
        .co        (co),
        .of        (of),
        .busy      (busy)
    );

    // Present one request while idle, then count edges until rsp_valid (-1 on timeout).
    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ici,
                         output int lat);
        int n;
        n = 0;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        a = ia; b = ib; ci = ici; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = -1;
        for (int k = 1; k <= 50; k++) begin
            if (rsp_valid) begin
                lat = k - 1;
                break;
            end
            @(posedge clk); #1;
            if (rsp_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        a = '0; b = '0; ci = 1'b0; op = 1'b0;
        #12;
        tests++;
        if (sum !== '0 || co !== 1'b0 || of !== 1'b0) begin
            fails++; $display("FAIL reset_result sum=%h co=%b of=%b want 0/0/0", sum, co, of);
        end
        tests++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL reset_flags rsp_valid=%b busy=%b want 0/0", rsp_valid, busy);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (req_ready !== 1'b1) begin
            fails++; $display("FAIL reset_req_ready got=%b want 1", req_ready);
        end
    endtask

    task automatic test_basic();
        int lat;
        rsp_ready = 1'b1;
        a = '0;
        issue(32'h0000_0001, 32'h0000_0002, 1'b0, lat);
        tests++;
        if (lat !== WORDS) begin
            fails++; $display("FAIL basic_latency got=%0d want %0d", lat, WORDS);
        end
        tests++;
        if (sum !== 32'h0000_0003 || co !== 1'b0 || of !== 1'b0 || busy !== 1'b1) begin
            fails++; $display("FAIL basic_result sum=%h co=%b of=%b busy=%b want 00000003/0/0/1", sum, co, of, busy);
        end
        handshake();
        tests++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            fails++; $display("FAIL basic_release rsp_valid=%b req_ready=%b want 0/1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_carry_ripple();
        int lat;
        issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, lat);
        tests++;
        if (lat !== WORDS || sum !== 32'h0000_0000 || co !== 1'b1 || of !== 1'b0) begin
            fails++; $display("FAIL ripple lat=%0d sum=%h co=%b of=%b want 4/00000000/1/0", lat, sum, co, of);
        end
        handshake();
    endtask

    task automatic test_overflow();
        int lat;
        issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, lat);
        tests++;
        if (lat !== WORDS || sum !== 32'h8000_0000 || co !== 1'b0 || of !== 1'b1) begin
            fails++; $display("FAIL overflow lat=%0d sum=%h co=%b of=%b want 4/80000000/0/1", lat, sum, co, of);
        end
        handshake();
        issue(32'h0000_00FF, 32'h0000_0000, 1'b1, lat);
        tests++;
        if (lat !== WORDS || sum !== 32'h0000_0100 || co !== 1'b0 || of !== 1'b0) begin
            fails++; $display("FAIL carry_in lat=%0d sum=%h co=%b of=%b want 4/00000100/0/0", lat, sum, co, of);
        end
        handshake();
    endtask

    task automatic test_back_to_back();
        int lat;
        int n;
        issue(32'h1020_3040, 32'h0102_0304, 1'b0, lat);
        tests++;
        if (lat !== WORDS || sum !== 32'h1122_3344) begin
            fails++; $display("FAIL bp_first lat=%0d sum=%h want 4/11223344", lat, sum);
        end
        // Stall the consumer while the requester pushes changing operands.
        req_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            a = 32'h0000_1000 + k; b = 32'h0000_0200 + k; ci = 1'b0;
            @(posedge clk); #1;
            tests++;
            if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || sum !== 32'h1122_3344 || co !== 1'b0 || of !== 1'b0) begin
                fails++; $display("FAIL bp_hold%0d rsp_valid=%b req_ready=%b sum=%h co=%b of=%b want 1/0/11223344/0/0",
                                  k, rsp_valid, req_ready, sum, co, of);
            end
        end
        a = 32'h0000_5555; b = 32'h0000_AAAA; ci = 1'b1;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        tests++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
            fails++; $display("FAIL bp_no_reaccept rsp_valid=%b busy=%b req_ready=%b want 0/0/1", rsp_valid, busy, req_ready);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        tests++;
        if (busy !== 1'b1 || req_ready !== 1'b0) begin
            fails++; $display("FAIL bp_accept busy=%b req_ready=%b want 1/0", busy, req_ready);
        end
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(posedge clk); #1; n++;
        end
        tests++;
        if (n !== WORDS || sum !== 32'h0001_0000 || co !== 1'b0 || of !== 1'b0) begin
            fails++; $display("FAIL bp_second lat=%0d sum=%h co=%b of=%b want 4/00010000/0/0", n, sum, co, of);
        end
        handshake();
    endtask

    task automatic test_reset_mid_run();
        int lat;
        a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; ci = 1'b1; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        tests++;
        if (sum !== 32'h0000_FFFF || busy !== 1'b1) begin
            fails++; $display("FAIL midrun_partial sum=%h busy=%b want 0000ffff/1", sum, busy);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (sum !== '0 || rsp_valid !== 1'b0 || busy !== 1'b0 || co !== 1'b0 || of !== 1'b0) begin
            fails++; $display("FAIL midrun_reset sum=%h rsp_valid=%b busy=%b co=%b of=%b want 0/0/0/0/0", sum, rsp_valid, busy, co, of);
        end
        #10;
        rst_n = 1'b1;
        @(posedge clk); #1;
        issue(32'h1234_5678, 32'h1111_1111, 1'b0, lat);
        tests++;
        if (lat !== WORDS || sum !== 32'h2345_6789 || co !== 1'b0 || of !== 1'b0) begin
            fails++; $display("FAIL midrun_after lat=%0d sum=%h co=%b of=%b want 4/23456789/0/0", lat, sum, co, of);
        end
        handshake();
    endtask

`ifdef ADDSEQ_SUB_EN
    task automatic test_sub();
        int lat;
        op = 1'b1;
        issue(32'h0000_0005, 32'h0000_0007, 1'b0, lat);
        tests++;
        if (lat !== WORDS || sum !== 32'hFFFF_FFFE || co !== 1'b0 || of !== 1'b0) begin
            fails++; $display("FAIL sub_borrow sum=%h co=%b of=%b want fffffffe/0/0", sum, co, of);
        end
        handshake();
        issue(32'h8000_0000, 32'h0000_0001, 1'b0, lat);
        tests++;
        if (lat !== WORDS || sum !== 32'h7FFF_FFFF || co !== 1'b1 || of !== 1'b1) begin
            fails++; $display("FAIL sub_overflow sum=%h co=%b of=%b want 7fffffff/1/1", sum, co, of);
        end
        handshake();
        op = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        rsp_ready = 1'b0;
        test_carry_ripple();
        test_overflow();
        test_back_to_back();
        test_reset_mid_run();
`ifdef ADDSEQ_SUB_EN
        test_sub();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Hard stop so a wedged DUT can never hang the run.
    initial begin
        #200000;
        $display("FAIL watchdog timeout tests=%0d", tests);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/adder_seq_ctrl.md
Name: adder_seq_ctrl

Overview:
- Multi-cycle wide-operand adder sequencer. Processes a WORDS*8-bit add one 8-bit slice per clock through a single shared 8-bit CLA slice (adder_8).
- Carry is chained between slices through a register.
- Sits between a requester, which uses a valid/ready request channel, and a consumer, which uses a valid/ready response channel. Trades latency for area on wide additions.

Parameters:
- WORDS, 4, number of 8-bit slices. Operand width W = 8*WORDS. Legal range 1..16.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request operands valid
- req_ready  out  1  block can accept a request
- a  in  W  operand A
- b  in  W  operand B
- ci  in  1  carry-in to slice 0
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result
- sum  out  W  result
- co  out  1  carry-out of top slice
- of  out  1  signed overflow: top-slice carry-out XOR carry into bit W-1
- busy  out  1  high in RUN or DONE

Behaviour:
- States: IDLE, RUN, DONE.
- Reset (rst_n low, asynchronous):
  - state=IDLE, slice index=0, carry reg=0.
  - Operand regs, sum, co and of are cleared to 0.
  - rsp_valid=0, busy=0. req_ready=1 from the first cycle after release.
- IDLE:
  - req_ready=1.
  - On a clock edge with req_valid&&req_ready: latch a, b into operand regs, carry reg<=ci, idx<=0, sum<=0, state<=RUN.
- RUN:
  - Each edge applies slice idx (a_r[8*idx+:8], b_r[8*idx+:8], carry reg) to adder_8.
  - Writes sum[8*idx+:8], carry reg<=slice co, idx<=idx+1.
  - On the edge processing idx==WORDS-1: co<=slice co, of<=slice of, state<=DONE.
- Latency: rsp_valid rises exactly WORDS edges after the accepting edge. WORDS=1 gives 1 cycle.
- DONE:
  - rsp_valid=1.
  - sum, co and of hold stable until an edge with rsp_ready=1; that edge sets state<=IDLE and rsp_valid<=0.
  - No same-cycle re-accept: req_ready=0 in DONE, so the next request is taken at the earliest one cycle after the response handshake.
- req_ready=0 in RUN and DONE. req_valid and operand changes in those states are ignored; latched operands are not disturbed.
- rsp_ready while not in DONE: ignored.
- sum is updated slice-by-slice during RUN. Consumers sample it only when rsp_valid=1.
- Arithmetic is modulo 2^W, unsigned. co is the true carry-out. of is the two's-complement overflow of the full W-bit operation.
- Reset asserted mid-RUN or mid-DONE: operation aborted, no response produced, all outputs return to reset values immediately.

Optional Feature:
- Macro: ADDSEQ_SUB_EN.
- Defined:
  - Adds input port op (1 bit), latched with the operands.
  - op=1 performs a-b: b slices are inverted before adder_8, carry reg is initialised to 1, and ci is ignored.
  - co=1 means no borrow. of is signed subtraction overflow.
  - op=0 behaves as addition.
- Undefined: op port absent; addition only, exactly as in Behaviour.

Decomposition:
- Package adder_seq_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_t
  - localparam SLICE_W=8
  - function idx_w(WORDS) returning the slice-counter width $clog2(WORDS) (minimum 1)
- Sub-module: one instance of the existing adder_8 (s, co, of, a, b, ci) as the shared slice datapath. No other sub-modules.
- FSM, counter, operand regs and result regs live in adder_seq_ctrl.

Test Plan (WORDS=4):
- a=0x00000001, b=0x00000002, ci=0, rsp_ready=1: rsp_valid rises 4 edges after accept; sum=0x00000003, co=0, of=0.
- a=0xFFFFFFFF, b=0x00000001, ci=0: sum=0x00000000, co=1, of=0 (carry ripples through all 4 slices).
- a=0x7FFFFFFF, b=0x00000001: sum=0x80000000, co=0, of=1. Then a=0x000000FF, b=0, ci=1: sum=0x00000100, co=0, of=0.
- Backpressure: rsp_ready=0 for 3 cycles after rsp_valid, with req_valid=1 and changing a/b. Response holds sum/co/of, req_ready stays 0, and the new request is accepted only after the rsp_ready handshake plus one cycle.
- Reset mid-RUN: assert rst_n=0 after 2 slices. sum=0, rsp_valid=0, busy=0 immediately. After release, a=0x12345678, b=0x11111111 gives sum=0x23456789.
- ADDSEQ_SUB_EN defined, op=1: a=0x00000005, b=0x00000007 gives sum=0xFFFFFFFE, co=0. a=0x80000000, b=1 gives sum=0x7FFFFFFF, of=1.
